udp_rx_pkt_buf: RTL and testbench
=================================

UDP_RX_PKT_BUF -- requirements
Module: udp_rx_pkt_buf

Interface
REQ-001 SHALL have parameter U_DLY, default 1: register assignment delay in ns, simulation only.
REQ-002 SHALL have parameter RAM_AW, default 12: data RAM address width in 32-bit words; depth = 2^RAM_AW.
REQ-003 SHALL have parameter DESC_AW, default 4: descriptor FIFO address width; depth = 2^DESC_AW.
REQ-004 SHALL have parameter PORT_NUM, default 4, range 1..16: number of accepted destination-port entries.
REQ-005 SHALL have port clk_sys, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port cfg_udp_filter, input, 1: 1 = port filtering enabled.
REQ-008 SHALL have port cfg_port_list, input, 16*PORT_NUM: entry k occupies bits [16k+15:16k].
REQ-009 SHALL have port udp_rx_length, input, 16: packet payload length in bytes; stable for the whole packet.
REQ-010 SHALL have port udp_rxdst_port, input, 16: packet destination port; stable for the whole packet.
REQ-011 SHALL have port udp_rxdata, input, 32: payload word; the first wire byte is in [31:24].
REQ-012 SHALL have port udp_rx_data_valid, input, 1: payload word strobe.
REQ-013 SHALL have port user_rx_data, output, 8: payload byte.
REQ-014 SHALL have ports user_rx_data_valid, user_rx_sop and user_rx_eop, output, 1 each: byte valid, first byte of packet, last byte of packet.
REQ-015 SHALL have port user_rx_chn, output, 4: index of the matched port entry (0 when the filter is off).
REQ-016 SHALL have port user_rx_ready, input, 1: sink accepts the current byte.
REQ-017 SHALL have ports pkt_cnt and drop_cnt, output, 16 each: accepted-packet and dropped-packet counters.

Function
REQ-018 SHALL compute word count W = ceil(udp_rx_length/4) as 14 bits; a packet is exactly W udp_rx_data_valid beats, tracked by a beat counter that wraps to 0 after beat W-1.
REQ-019 SHALL ignore packets with udp_rx_length = 0: no write, no descriptor, no count change.
REQ-020 SHALL decide accept or drop on beat 0 and hold that decision for the whole packet.
REQ-021 SHALL accept a packet only when all hold: (cfg_udp_filter = 0, or udp_rxdst_port equals some entry, lowest matching index wins), free words >= W, and the descriptor FIFO is not full.
REQ-022 SHALL, for a dropped packet, write nothing, increment drop_cnt once on beat 0, and saturate drop_cnt at 0xFFFF.
REQ-023 SHALL, for an accepted packet, write each word at the write pointer with bytes reversed ({d[7:0],d[15:8],d[23:16],d[31:24]}), then increment the write pointer modulo 2^RAM_AW.
REQ-024 SHALL push descriptor {chn, start address, length} on the cycle after the last beat, and increment pkt_cnt there (wraps).
REQ-025 SHALL track free words = 2^RAM_AW minus words held; reserve W on accept and release W at eop handshake; a same-cycle reserve and release both apply.
REQ-026 SHALL implement the read-side state machine IDLE -> LOAD -> STREAM -> IDLE: IDLE pops a descriptor when the FIFO is non-empty; LOAD sets the byte read address = start*4 (1 cycle); STREAM emits udp_rx_length bytes, padding bytes excluded.
REQ-027 SHALL make the byte handshake valid/ready: a transfer happens when user_rx_data_valid && user_rx_ready; while valid && !ready, data, sop, eop and chn are held stable.
REQ-028 SHALL produce the first user_rx_data_valid at most 3 cycles after the descriptor FIFO becomes non-empty in IDLE, and sustain one byte per cycle while ready = 1.
REQ-029 SHALL let byte address arithmetic wrap modulo 2^(RAM_AW+2), so packets may straddle the RAM end.
REQ-030 SHALL accept writes and reads concurrently without loss.

Reset
REQ-031 SHALL, while rst_n = 0, asynchronously clear all outputs to 0, both pointers, the beat counter, both counters, the descriptor FIFO (empty), and the FSM (IDLE), and set free words = 2^RAM_AW.
REQ-032 SHALL, on reset mid-packet, discard the in-flight packet; after release, the next beat is treated as beat 0.

Verification
REQ-033 Filter off, length 6, words 0x01020304 and 0x0506xxxx, ready = 1 -> bytes 01..06, sop on 01, eop on 06, chn 0, pkt_cnt 1.
REQ-034 Filter on, list {0x1000,0x2000,0x3000,0x4000}, dst 0x3000 -> chn 2; dst 0x5000 -> no output, drop_cnt +1.
REQ-035 RAM_AW = 4, two 40-byte packets back-to-back with ready = 0 -> first accepted, second dropped (free 6 < 10); after the first drains, a third 40-byte packet is accepted and wraps the RAM end, with correct bytes out.
REQ-036 ready toggling 1/0 every cycle during a 9-byte packet -> 9 transfers, data stable during stalls, eop only on the 9th.
REQ-037 DESC_AW = 1, three 4-byte packets with ready = 0 -> two accepted, third dropped (FIFO full).
REQ-038 rst_n pulsed low at beat 2 of a 5-word packet -> all outputs 0; a subsequent clean packet is received correctly.

Source files
------------

// File: rtl/udp_rx_pkt_buf.sv
// UDP receive packet buffer: filters incoming payload words into a circular word RAM
// and replays accepted packets as a valid/ready byte stream with sop/eop/channel tags.
module udp_rx_pkt_buf #(
   parameter int U_DLY    = 1,
   parameter int RAM_AW   = 12,
   parameter int DESC_AW  = 4,
   parameter int PORT_NUM = 4
) (
   input  logic                   clk_sys,
   input  logic                   rst_n,
   input  logic                   cfg_udp_filter,
   input  logic [16*PORT_NUM-1:0] cfg_port_list,
   input  logic [15:0]            udp_rx_length,
   input  logic [15:0]            udp_rxdst_port,
   input  logic [31:0]            udp_rxdata,
   input  logic                   udp_rx_data_valid,
   output logic [7:0]             user_rx_data,
   output logic                   user_rx_data_valid,
   output logic                   user_rx_sop,
   output logic                   user_rx_eop,
   output logic [3:0]             user_rx_chn,
   input  logic                   user_rx_ready,
   output logic [15:0]            pkt_cnt,
   output logic [15:0]            drop_cnt
);

   localparam int RAM_DEPTH  = 2**RAM_AW;
   localparam int DESC_DEPTH = 2**DESC_AW;
   localparam int DESC_W     = 4 + RAM_AW + 16;
   localparam int CW         = (RAM_AW + 1 > 14) ? RAM_AW + 1 : 14;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} rd_state_t;

   // U_DLY only models register delay in simulation; nothing to build for it here.
   if (U_DLY < 0) begin : g_neg_dly
   end

   logic [31:0]         ram [RAM_DEPTH];
   logic [DESC_W-1:0]   desc_mem [DESC_DEPTH];
   logic [DESC_AW:0]    desc_wp, desc_rp, desc_count;
   logic [DESC_AW+1:0]  desc_used;
   logic                desc_full_eff, desc_pop, push_pend;
   logic [DESC_W-1:0]   push_data;

   logic [13:0]         word_cnt, beat_cnt, reserve_w, release_w, cur_words;
   logic                beat, first_beat, last_beat, match_hit, accept_now, acc_eff, ram_we;
   logic                pkt_acc;
   logic [3:0]          match_chn, chn_eff, pkt_chn;
   logic [RAM_AW-1:0]   wr_ptr, pkt_start, start_eff;
   logic [RAM_AW:0]     free_words;

   rd_state_t           state, next_state;
   logic [3:0]          cur_chn;
   logic [RAM_AW-1:0]   cur_start;
   logic [15:0]         cur_len, remaining;
   logic [RAM_AW+1:0]   rd_baddr;
   logic [31:0]         rd_word;
   logic                sop_pend, xfer, load_byte, rel_en;

   assign word_cnt   = 14'((17'(udp_rx_length) + 17'd3) >> 2);
   assign cur_words  = 14'((17'(cur_len) + 17'd3) >> 2);
   assign beat       = udp_rx_data_valid && (udp_rx_length != 16'd0);
   assign first_beat = beat && (beat_cnt == 14'd0);
   assign last_beat  = beat && (beat_cnt == word_cnt - 14'd1);
   assign desc_count = desc_wp - desc_rp;
   assign desc_used  = {1'b0, desc_count} + (DESC_AW+2)'(push_pend);
   // A descriptor still waiting to be pushed already occupies a FIFO slot.
   assign desc_full_eff = desc_used >= (DESC_AW+2)'(DESC_DEPTH);

   // Lowest matching entry wins, so scan from the top and let later hits overwrite.
   always_comb begin
      match_hit = 1'b0;
      match_chn = 4'd0;
      for (int k = PORT_NUM - 1; k >= 0; k--) begin
         if (udp_rxdst_port == cfg_port_list[16*k +: 16]) begin
            match_hit = 1'b1;
            match_chn = 4'(k);
         end
      end
   end

   assign accept_now = (!cfg_udp_filter || match_hit) &&
                       (CW'(free_words) >= CW'(word_cnt)) && !desc_full_eff;
   assign acc_eff    = first_beat ? accept_now : pkt_acc;
   assign ram_we     = beat && acc_eff;
   assign chn_eff    = first_beat ? (cfg_udp_filter ? match_chn : 4'd0) : pkt_chn;
   assign start_eff  = first_beat ? wr_ptr : pkt_start;
   assign reserve_w  = (first_beat && accept_now) ? word_cnt : 14'd0;
   assign release_w  = rel_en ? cur_words : 14'd0;

   always_ff @(posedge clk_sys) begin
      if (ram_we)
         ram[wr_ptr] <= {udp_rxdata[7:0], udp_rxdata[15:8], udp_rxdata[23:16], udp_rxdata[31:24]};
      if (push_pend)
         desc_mem[desc_wp[DESC_AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         pkt_acc    <= 1'b0;
         pkt_chn    <= '0;
         pkt_start  <= '0;
         wr_ptr     <= '0;
         push_pend  <= 1'b0;
         push_data  <= '0;
         desc_wp    <= '0;
         pkt_cnt    <= '0;
         drop_cnt   <= '0;
         free_words <= (RAM_AW+1)'(RAM_DEPTH);
      end else begin
         if (beat)
            beat_cnt <= last_beat ? 14'd0 : beat_cnt + 14'd1;
         if (first_beat) begin
            pkt_acc   <= accept_now;
            pkt_chn   <= chn_eff;
            pkt_start <= wr_ptr;
            if (!accept_now && drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end
         if (ram_we)
            wr_ptr <= wr_ptr + 1'b1;
         push_pend <= last_beat && acc_eff;
         if (last_beat && acc_eff)
            push_data <= {chn_eff, start_eff, udp_rx_length};
         if (push_pend) begin
            desc_wp <= desc_wp + 1'b1;
            pkt_cnt <= pkt_cnt + 16'd1;
         end
         free_words <= free_words - (RAM_AW+1)'(reserve_w) + (RAM_AW+1)'(release_w);
      end
   end

   assign rd_word   = ram[rd_baddr[RAM_AW+1:2]];
   assign xfer      = user_rx_data_valid && user_rx_ready;
   assign rel_en    = xfer && user_rx_eop;
   assign load_byte = (state == S_STREAM) && (remaining != 16'd0) &&
                      (!user_rx_data_valid || user_rx_ready);

   // Stay in STREAM until the eop byte is actually taken so its words are released once.
   always_comb begin
      next_state = state;
      desc_pop   = 1'b0;
      case (state)
         S_IDLE: begin
            if (desc_count != '0) begin
               desc_pop   = 1'b1;
               next_state = S_LOAD;
            end
         end
         S_LOAD:   next_state = S_STREAM;
         S_STREAM: if (rel_en) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         desc_rp            <= '0;
         cur_chn            <= '0;
         cur_start          <= '0;
         cur_len            <= '0;
         rd_baddr           <= '0;
         remaining          <= '0;
         sop_pend           <= 1'b0;
         user_rx_data       <= '0;
         user_rx_data_valid <= 1'b0;
         user_rx_sop        <= 1'b0;
         user_rx_eop        <= 1'b0;
         user_rx_chn        <= '0;
      end else begin
         state <= next_state;
         if (desc_pop) begin
            {cur_chn, cur_start, cur_len} <= desc_mem[desc_rp[DESC_AW-1:0]];
            desc_rp <= desc_rp + 1'b1;
         end
         if (state == S_LOAD) begin
            rd_baddr  <= {cur_start, 2'b00};
            remaining <= cur_len;
            sop_pend  <= 1'b1;
         end
         if (load_byte) begin
            user_rx_data       <= rd_word[{rd_baddr[1:0], 3'b000} +: 8];
            user_rx_data_valid <= 1'b1;
            user_rx_sop        <= sop_pend;
            user_rx_eop        <= (remaining == 16'd1);
            user_rx_chn        <= cur_chn;
            rd_baddr           <= rd_baddr + 1'b1;
            remaining          <= remaining - 16'd1;
            sop_pend           <= 1'b0;
         end else if (xfer) begin
            user_rx_data_valid <= 1'b0;
            user_rx_sop        <= 1'b0;
            user_rx_eop        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// Self-checking bench for udp_rx_pkt_buf: table-driven packets plus corner sequences,
// with every accepted byte checked against a scoreboard queue.
module tb_udp_rx_pkt_buf;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        cfg_udp_filter;
   logic [63:0] cfg_port_list;
   logic [15:0] udp_rx_length;
   logic [15:0] udp_rxdst_port;
   logic [31:0] udp_rxdata;
   logic        udp_rx_data_valid;
   logic [7:0]  user_rx_data;
   logic        user_rx_data_valid;
   logic        user_rx_sop;
   logic        user_rx_eop;
   logic [3:0]  user_rx_chn;
   logic        user_rx_ready;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pkt  = 0;
   int exp_drop = 0;
   logic [13:0] exp_q[$];
   logic        ready_level = 1'b1;
   logic        toggle_mode = 1'b0;
   logic        prev_stall  = 1'b0;
   logic [14:0] prev_bus    = '0;

   typedef struct {
      logic        filt;
      logic [15:0] dst;
      int          len;
      logic [7:0]  seed;
      bit          acc;
      logic [3:0]  chn;
   } vec_t;

   vec_t vecs[7];

   udp_rx_pkt_buf #(.RAM_AW(4), .DESC_AW(1), .PORT_NUM(4)) dut (
      .clk_sys            (clk_sys),
      .rst_n              (rst_n),
      .cfg_udp_filter     (cfg_udp_filter),
      .cfg_port_list      (cfg_port_list),
      .udp_rx_length      (udp_rx_length),
      .udp_rxdst_port     (udp_rxdst_port),
      .udp_rxdata         (udp_rxdata),
      .udp_rx_data_valid  (udp_rx_data_valid),
      .user_rx_data       (user_rx_data),
      .user_rx_data_valid (user_rx_data_valid),
      .user_rx_sop        (user_rx_sop),
      .user_rx_eop        (user_rx_eop),
      .user_rx_chn        (user_rx_chn),
      .user_rx_ready      (user_rx_ready),
      .pkt_cnt            (pkt_cnt),
      .drop_cnt           (drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   // Sink ready: either a steady level or toggling every cycle.
   initial begin
      user_rx_ready = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         user_rx_ready = toggle_mode ? ~user_rx_ready : ready_level;
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every handshaked byte must match the queue head.
   always @(negedge clk_sys) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check_output("stall_hold",
                         {17'd0, user_rx_data_valid, user_rx_chn, user_rx_sop, user_rx_eop, user_rx_data},
                         {17'd0, prev_bus});
         if (user_rx_data_valid && user_rx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no transfer", user_rx_data);
            end else begin
               check_output("byte", {18'd0, user_rx_chn, user_rx_sop, user_rx_eop, user_rx_data},
                            {18'd0, exp_q.pop_front()});
            end
         end
         prev_stall = user_rx_data_valid && !user_rx_ready;
         prev_bus   = {user_rx_data_valid, user_rx_chn, user_rx_sop, user_rx_eop, user_rx_data};
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Drives one packet as back-to-back beats; expected bytes go to the scoreboard now.
   task automatic apply_stimulus(input int len, input logic [15:0] dst, input logic [7:0] seed,
                                 input bit acc, input logic [3:0] chn);
      int nw;
      logic [31:0] word;
      logic [7:0]  b;
      udp_rx_length  = 16'(len);
      udp_rxdst_port = dst;
      nw = (len == 0) ? 1 : (len + 3) / 4;
      if (len != 0) begin
         if (acc) exp_pkt++;
         else     exp_drop++;
         if (acc)
            for (int i = 0; i < len; i++)
               exp_q.push_back({chn, (i == 0), (i == len - 1), 8'(seed + i)});
      end
      for (int w = 0; w < nw; w++) begin
         word = '0;
         for (int j = 0; j < 4; j++) begin
            b    = (4*w + j < len) ? 8'(seed + 4*w + j) : 8'hEE;
            word = {word[23:0], b};
         end
         udp_rxdata        = word;
         udp_rx_data_valid = 1'b1;
         @(posedge clk_sys);
         #1;
      end
      udp_rx_data_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 2000) begin
         @(posedge clk_sys);
         cyc++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      idle(4);
   endtask

   task automatic check_counters(input string tag);
      check_output({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'(exp_pkt));
      check_output({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'(exp_drop));
   endtask

   task automatic reset_check(input string tag);
      check_output({tag, "_valid"}, {31'd0, user_rx_data_valid}, 32'd0);
      check_output({tag, "_data"}, {24'd0, user_rx_data}, 32'd0);
      check_output({tag, "_sop"}, {31'd0, user_rx_sop}, 32'd0);
      check_output({tag, "_eop"}, {31'd0, user_rx_eop}, 32'd0);
      check_output({tag, "_chn"}, {28'd0, user_rx_chn}, 32'd0);
      check_output({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
      check_output({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
   endtask

   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      udp_rx_data_valid = 1'b0;
      exp_q.delete();
      exp_pkt  = 0;
      exp_drop = 0;
      @(negedge clk_sys);
      reset_check(tag);
      @(negedge clk_sys);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{filt: 1'b0, dst: 16'h1234, len: 6,  seed: 8'h01, acc: 1'b1, chn: 4'd0};
      vecs[1] = '{filt: 1'b1, dst: 16'h3000, len: 5,  seed: 8'h10, acc: 1'b1, chn: 4'd2};
      vecs[2] = '{filt: 1'b1, dst: 16'h5000, len: 8,  seed: 8'h20, acc: 1'b0, chn: 4'd0};
      vecs[3] = '{filt: 1'b1, dst: 16'h1000, len: 1,  seed: 8'h30, acc: 1'b1, chn: 4'd0};
      vecs[4] = '{filt: 1'b1, dst: 16'h4000, len: 12, seed: 8'h90, acc: 1'b1, chn: 4'd3};
      vecs[5] = '{filt: 1'b0, dst: 16'h5000, len: 3,  seed: 8'hA0, acc: 1'b1, chn: 4'd0};
      vecs[6] = '{filt: 1'b1, dst: 16'h2000, len: 0,  seed: 8'hB0, acc: 1'b0, chn: 4'd0};

      rst_n             = 1'b0;
      cfg_udp_filter    = 1'b0;
      cfg_port_list     = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
      udp_rx_length     = '0;
      udp_rxdst_port    = '0;
      udp_rxdata        = '0;
      udp_rx_data_valid = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_check("por");
      rst_n = 1'b1;
      idle(2);

      $display("[TB] table-driven packets");
      for (int i = 0; i < 7; i++) begin
         cfg_udp_filter = vecs[i].filt;
         apply_stimulus(vecs[i].len, vecs[i].dst, vecs[i].seed, vecs[i].acc, vecs[i].chn);
         wait_drain();
         check_counters($sformatf("vec%0d", i));
      end

      $display("[TB] RAM full drop and wrap");
      reset_dut("rst_a");
      cfg_udp_filter = 1'b0;
      ready_level    = 1'b0;
      idle(2);
      apply_stimulus(40, 16'h0001, 8'h40, 1'b1, 4'd0);
      apply_stimulus(40, 16'h0001, 8'h80, 1'b0, 4'd0);
      idle(10);
      check_counters("ramfull");
      check_output("ramfull_held_valid", {31'd0, user_rx_data_valid}, 32'd1);
      check_output("ramfull_held_data", {24'd0, user_rx_data}, 32'h40);
      ready_level = 1'b1;
      wait_drain();
      apply_stimulus(40, 16'h0001, 8'hC0, 1'b1, 4'd0);
      wait_drain();
      check_counters("wrap");

      $display("[TB] descriptor FIFO full");
      ready_level = 1'b0;
      idle(2);
      apply_stimulus(4, 16'h0001, 8'h31, 1'b1, 4'd0);
      apply_stimulus(4, 16'h0001, 8'h41, 1'b1, 4'd0);
      apply_stimulus(4, 16'h0001, 8'h51, 1'b0, 4'd0);
      idle(6);
      check_counters("descfull");
      ready_level = 1'b1;
      wait_drain();

      $display("[TB] ready toggling");
      toggle_mode = 1'b1;
      apply_stimulus(9, 16'h0001, 8'h61, 1'b1, 4'd0);
      wait_drain();
      toggle_mode = 1'b0;
      ready_level = 1'b1;
      idle(2);
      check_counters("toggle");

      $display("[TB] reset mid-packet");
      ready_level = 1'b0;
      idle(2);
      apply_stimulus(4, 16'h0001, 8'h71, 1'b1, 4'd0);
      idle(5);
      udp_rx_length  = 16'd20;
      udp_rxdst_port = 16'h0001;
      for (int w = 0; w < 3; w++) begin
         udp_rxdata        = {8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)};
         udp_rx_data_valid = 1'b1;
         if (w < 2) begin
            @(posedge clk_sys);
            #1;
         end
      end
      #2;
      rst_n             = 1'b0;
      udp_rx_data_valid = 1'b0;
      exp_q.delete();
      exp_pkt  = 0;
      exp_drop = 0;
      @(negedge clk_sys);
      reset_check("rst_mid");
      @(negedge clk_sys);
      rst_n       = 1'b1;
      ready_level = 1'b1;
      idle(3);
      apply_stimulus(7, 16'h0001, 8'hD1, 1'b1, 4'd0);
      wait_drain();
      check_counters("post_rst");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
